// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: two-port (fetch/loader) arbiter in front of a single-port instruction memory.
// Ports:
//   clk, rst                      clock and asynchronous active-low reset
//   f_req/f_addr                  fetch read request and byte address
//   f_gnt/f_rvalid/f_rdata/f_err  fetch grant, response valid, read data, out-of-range flag
//   l_req/l_we/l_addr/l_wdata     loader request, write enable, byte address, write data
//   l_lock                        loader requests an exclusive session
//   l_gnt/l_rvalid/l_rdata        loader grant, response valid, read data
//   m_en/m_we/m_addr/m_wdata      memory access enable, write enable, word index, write data
//   m_rdata                       memory read data, valid one cycle after m_en
//   locked                        exclusive loader session in progress
//   wr_cnt                        loader writes accepted in the current or last session
// Build option: IMEM_RR_EN selects round-robin IDLE arbitration (default: loader has priority).
module imem_port_arbiter #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          f_req,
   input  logic [31:0]   f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [31:0]   f_rdata,
   output logic          f_err,
   input  logic          l_req,
   input  logic          l_we,
   input  logic [31:0]   l_addr,
   input  logic [31:0]   l_wdata,
   input  logic          l_lock,
   output logic          l_gnt,
   output logic          l_rvalid,
   output logic [31:0]   l_rdata,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [31:0]   m_wdata,
   input  logic [31:0]   m_rdata,
   output logic          locked,
   output logic [AW:0]   wr_cnt
);
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t      state_q, state_d;
   logic        f_pend_q, f_pend_d, l_pend_q, l_pend_d;
   logic        f_oor_q, f_oor_d, zero_q, zero_d;
   logic [AW:0] wr_cnt_q, wr_cnt_d;
   logic        lock_s, loader_pri, l_win, f_win, any_gnt, oor, l_wr;
   logic [31:0] sel_addr;
   logic        unused_addr;
`ifdef IMEM_RR_EN
   // 1 = loader won the last IDLE grant; on conflict the other side wins
   logic        last_q, last_d;
   assign loader_pri = ~last_q;
`else
   assign loader_pri = 1'b1;
`endif
   always_comb begin
      lock_s   = state_q == LOCKED;
      l_win    = rst & l_req & (lock_s | ~f_req | loader_pri);
      f_win    = rst & f_req & ~lock_s & ~l_win;
      any_gnt  = l_win | f_win;
      sel_addr = l_win ? l_addr : f_addr;
      oor      = |sel_addr[31:AW+2];
      l_wr     = l_win & l_we;
      state_d  = lock_s ? (l_lock ? LOCKED : IDLE) : ((l_win & l_lock) ? LOCKED : IDLE);
      // session entry restarts the count, including the entering access itself
      wr_cnt_d = (~lock_s & l_win & l_lock) ? {{AW{1'b0}}, l_wr} :
                 (l_wr & ~wr_cnt_q[AW]) ? wr_cnt_q + 1'b1 : wr_cnt_q;
      f_pend_d = f_win;
      l_pend_d = l_win;
      f_oor_d  = f_win & oor;
      zero_d   = oor | l_wr;
`ifdef IMEM_RR_EN
      last_d   = (any_gnt & ~lock_s) ? l_win : last_q;
`endif
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         f_pend_q <= 1'b0;
         l_pend_q <= 1'b0;
         f_oor_q  <= 1'b0;
         zero_q   <= 1'b0;
         wr_cnt_q <= '0;
`ifdef IMEM_RR_EN
         last_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         f_pend_q <= f_pend_d;
         l_pend_q <= l_pend_d;
         f_oor_q  <= f_oor_d;
         zero_q   <= zero_d;
         wr_cnt_q <= wr_cnt_d;
`ifdef IMEM_RR_EN
         last_q   <= last_d;
`endif
      end
   end
   assign unused_addr = ^sel_addr[1:0];
   assign f_gnt    = f_win;
   assign l_gnt    = l_win;
   assign m_en     = any_gnt & ~oor;
   assign m_we     = l_wr & ~oor;
   assign m_addr   = any_gnt ? sel_addr[AW+1:2] : '0;
   assign m_wdata  = l_win ? l_wdata : '0;
   assign f_rvalid = f_pend_q;
   assign f_err    = f_oor_q;
   assign f_rdata  = (f_pend_q & ~zero_q) ? m_rdata : '0;
   assign l_rvalid = l_pend_q;
   assign l_rdata  = (l_pend_q & ~zero_q) ? m_rdata : '0;
   assign locked   = state_q == LOCKED;
   assign wr_cnt   = wr_cnt_q;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed self-checking bench for imem_port_arbiter with a behavioural memory.
module tb_imem_port_arbiter;
   localparam int AW = 10;
   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          f_req = 1'b0, l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
   logic [31:0]   f_addr = '0, l_addr = '0, l_wdata = '0;
   logic          f_gnt, f_rvalid, f_err, l_gnt, l_rvalid, m_en, m_we, locked;
   logic [31:0]   f_rdata, l_rdata, m_wdata;
   logic [31:0]   m_rdata = '0;
   logic [AW-1:0] m_addr;
   logic [AW:0]   wr_cnt;
   logic [31:0]   mem [2**AW];
   logic [31:0]   wd [4];
   int            checks = 0;
   int            failures = 0;

   imem_port_arbiter #(.AW(AW)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
      .locked(locked), .wr_cnt(wr_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (m_en) begin
         if (m_we) mem[m_addr] <= m_wdata;
         m_rdata <= mem[m_addr];
      end
   end

   task automatic clear_inputs;
      f_req = 1'b0; l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0;
      f_addr = '0; l_addr = '0; l_wdata = '0;
   endtask

   task automatic test_reset;
      f_req = 1'b1; l_req = 1'b1; l_lock = 1'b1; l_we = 1'b1;
      #1;
      checks++; if (f_gnt !== 1'b0 || l_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got f=%0b l=%0b exp 0/0", f_gnt, l_gnt); end
      checks++; if (m_en !== 1'b0 || m_we !== 1'b0) begin failures++; $display("FAIL reset_mem got en=%0b we=%0b exp 0/0", m_en, m_we); end
      @(posedge clk); #1;
      checks++; if (f_rvalid !== 1'b0 || l_rvalid !== 1'b0 || f_err !== 1'b0) begin failures++; $display("FAIL reset_resp got fv=%0b lv=%0b fe=%0b exp 0", f_rvalid, l_rvalid, f_err); end
      checks++; if (locked !== 1'b0 || wr_cnt !== '0) begin failures++; $display("FAIL reset_state got locked=%0b wr_cnt=%0d exp 0/0", locked, wr_cnt); end
      checks++; if (f_rdata !== '0 || l_rdata !== '0) begin failures++; $display("FAIL reset_rdata got f=%h l=%h exp 0", f_rdata, l_rdata); end
      @(negedge clk); clear_inputs(); rst = 1'b1;
   endtask

   task automatic test_fetch;
      @(negedge clk); f_req = 1'b1; f_addr = 32'h8; #1;
      checks++; if (f_gnt !== 1'b1 || l_gnt !== 1'b0) begin failures++; $display("FAIL fetch_gnt got f=%0b l=%0b exp 1/0", f_gnt, l_gnt); end
      checks++; if (m_en !== 1'b1 || m_addr !== 10'd2) begin failures++; $display("FAIL fetch_maddr got en=%0b addr=%0d exp 1/2", m_en, m_addr); end
      @(posedge clk); #1;
      checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEADBEEF || f_err !== 1'b0) begin failures++; $display("FAIL fetch_resp got v=%0b d=%h e=%0b exp 1/deadbeef/0", f_rvalid, f_rdata, f_err); end
      @(negedge clk); f_addr = 32'hB; #1;
      checks++; if (m_addr !== 10'd2) begin failures++; $display("FAIL fetch_byte_bits got addr=%0d exp 2", m_addr); end
      @(posedge clk); #1;
      checks++; if (f_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_byte_data got %h exp deadbeef", f_rdata); end
      @(negedge clk); clear_inputs(); #1;
      checks++; if (f_gnt !== 1'b0 || m_en !== 1'b0) begin failures++; $display("FAIL fetch_idle got gnt=%0b en=%0b exp 0/0", f_gnt, m_en); end
   endtask

   task automatic test_lock;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         f_req = 1'b1; f_addr = 32'h0; l_req = 1'b1; l_lock = 1'b1; l_we = 1'b1;
         l_addr = 32'(i * 4); l_wdata = wd[i]; #1;
         checks++; if (f_gnt !== 1'b0 || l_gnt !== 1'b1) begin failures++; $display("FAIL lock_gnt%0d got f=%0b l=%0b exp 0/1", i, f_gnt, l_gnt); end
         checks++; if (m_we !== 1'b1 || m_addr !== AW'(i) || m_wdata !== wd[i]) begin failures++; $display("FAIL lock_wr%0d got we=%0b addr=%0d d=%h exp 1/%0d/%h", i, m_we, m_addr, m_wdata, i, wd[i]); end
         @(posedge clk); #1;
         checks++; if (locked !== 1'b1 || wr_cnt !== (i + 1)) begin failures++; $display("FAIL lock_cnt%0d got locked=%0b wr_cnt=%0d exp 1/%0d", i, locked, wr_cnt, i + 1); end
         checks++; if (l_rvalid !== 1'b1 || l_rdata !== '0) begin failures++; $display("FAIL lock_resp%0d got v=%0b d=%h exp 1/0", i, l_rvalid, l_rdata); end
      end
      @(negedge clk); l_req = 1'b0; #1;
      checks++; if (f_gnt !== 1'b0 || l_gnt !== 1'b0 || m_en !== 1'b0) begin failures++; $display("FAIL lock_hold got f=%0b l=%0b en=%0b exp 0", f_gnt, l_gnt, m_en); end
      @(posedge clk); #1;
      checks++; if (locked !== 1'b1 || wr_cnt !== 11'd3) begin failures++; $display("FAIL lock_hold_state got locked=%0b wr_cnt=%0d exp 1/3", locked, wr_cnt); end
      @(negedge clk); l_req = 1'b1; l_lock = 1'b0; l_addr = 32'hC; l_wdata = wd[3]; #1;
      checks++; if (f_gnt !== 1'b0 || l_gnt !== 1'b1) begin failures++; $display("FAIL lock_final_gnt got f=%0b l=%0b exp 0/1", f_gnt, l_gnt); end
      @(posedge clk); #1;
      checks++; if (locked !== 1'b0 || wr_cnt !== 11'd4) begin failures++; $display("FAIL lock_exit got locked=%0b wr_cnt=%0d exp 0/4", locked, wr_cnt); end
      @(negedge clk); l_req = 1'b0; l_we = 1'b0; f_addr = 32'h8; #1;
      checks++; if (f_gnt !== 1'b1) begin failures++; $display("FAIL unlock_fetch_gnt got %0b exp 1", f_gnt); end
      @(posedge clk); #1;
      checks++; if (f_rvalid !== 1'b1 || f_rdata !== wd[2]) begin failures++; $display("FAIL unlock_fetch_data got v=%0b d=%h exp 1/%h", f_rvalid, f_rdata, wd[2]); end
      @(negedge clk); clear_inputs();
   endtask

   task automatic test_out_of_range;
      @(negedge clk); f_req = 1'b1; f_addr = 32'h1000; #1;
      checks++; if (f_gnt !== 1'b1 || m_en !== 1'b0) begin failures++; $display("FAIL oor_fetch_gnt got gnt=%0b en=%0b exp 1/0", f_gnt, m_en); end
      @(posedge clk); #1;
      checks++; if (f_rvalid !== 1'b1 || f_err !== 1'b1 || f_rdata !== '0) begin failures++; $display("FAIL oor_fetch_resp got v=%0b e=%0b d=%h exp 1/1/0", f_rvalid, f_err, f_rdata); end
      @(negedge clk); f_addr = 32'h8000_0008; #1;
      checks++; if (f_gnt !== 1'b1 || m_en !== 1'b0) begin failures++; $display("FAIL oor_msb_gnt got gnt=%0b en=%0b exp 1/0", f_gnt, m_en); end
      @(negedge clk); f_req = 1'b0; l_req = 1'b1; l_we = 1'b1; l_addr = 32'h1000_0000; l_wdata = 32'hFFFF_FFFF; #1;
      checks++; if (l_gnt !== 1'b1 || m_en !== 1'b0 || m_we !== 1'b0) begin failures++; $display("FAIL oor_wr_gnt got gnt=%0b en=%0b we=%0b exp 1/0/0", l_gnt, m_en, m_we); end
      @(posedge clk); #1;
      checks++; if (l_rvalid !== 1'b1 || l_rdata !== '0 || f_err !== 1'b0) begin failures++; $display("FAIL oor_wr_resp got v=%0b d=%h fe=%0b exp 1/0/0", l_rvalid, l_rdata, f_err); end
      checks++; if (wr_cnt !== 11'd5 || locked !== 1'b0) begin failures++; $display("FAIL oor_wr_cnt got wr_cnt=%0d locked=%0b exp 5/0", wr_cnt, locked); end
      @(negedge clk); clear_inputs();
   endtask

   task automatic test_conflict;
      logic exp_l;
      @(negedge clk); f_req = 1'b1; f_addr = 32'h8; #1;
      checks++; if (f_gnt !== 1'b1) begin failures++; $display("FAIL conflict_pre got %0b exp 1", f_gnt); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); f_req = 1'b1; f_addr = 32'h8; l_req = 1'b1; l_we = 1'b0; l_lock = 1'b0; l_addr = 32'h4;
`ifdef IMEM_RR_EN
         exp_l = (i % 2) == 0;
`else
         exp_l = 1'b1;
`endif
         #1;
         checks++; if (l_gnt !== exp_l || f_gnt !== !exp_l) begin failures++; $display("FAIL conflict_gnt%0d got l=%0b f=%0b exp l=%0b", i, l_gnt, f_gnt, exp_l); end
         @(posedge clk); #1;
         if (exp_l) begin
            checks++; if (l_rvalid !== 1'b1 || f_rvalid !== 1'b0 || l_rdata !== wd[1]) begin failures++; $display("FAIL conflict_l%0d got lv=%0b fv=%0b d=%h exp 1/0/%h", i, l_rvalid, f_rvalid, l_rdata, wd[1]); end
         end else begin
            checks++; if (f_rvalid !== 1'b1 || l_rvalid !== 1'b0 || f_rdata !== wd[2]) begin failures++; $display("FAIL conflict_f%0d got fv=%0b lv=%0b d=%h exp 1/0/%h", i, f_rvalid, l_rvalid, f_rdata, wd[2]); end
         end
      end
      checks++; if (locked !== 1'b0 || wr_cnt !== 11'd5) begin failures++; $display("FAIL conflict_state got locked=%0b wr_cnt=%0d exp 0/5", locked, wr_cnt); end
      @(negedge clk); clear_inputs();
   endtask

   task automatic test_reset_mid;
      @(negedge clk); f_req = 1'b1; f_addr = 32'h8; #1;
      checks++; if (f_gnt !== 1'b1) begin failures++; $display("FAIL rstmid_gnt got %0b exp 1", f_gnt); end
      @(posedge clk); #1; rst = 1'b0; #1;
      checks++; if (f_rvalid !== 1'b0 || f_rdata !== '0) begin failures++; $display("FAIL rstmid_resp got v=%0b d=%h exp 0/0", f_rvalid, f_rdata); end
      checks++; if (locked !== 1'b0 || wr_cnt !== '0 || f_gnt !== 1'b0) begin failures++; $display("FAIL rstmid_state got locked=%0b wr_cnt=%0d gnt=%0b exp 0/0/0", locked, wr_cnt, f_gnt); end
      @(posedge clk); #1;
      checks++; if (f_rvalid !== 1'b0) begin failures++; $display("FAIL rstmid_next got %0b exp 0", f_rvalid); end
      @(negedge clk); clear_inputs(); rst = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 2**AW; i++) mem[i] = '0;
      mem[2] = 32'hDEADBEEF;
      wd[0] = 32'h1111_0000; wd[1] = 32'h2222_0004; wd[2] = 32'h3333_0008; wd[3] = 32'h4444_000C;
      test_reset();
      test_fetch();
      test_lock();
      test_out_of_range();
      test_conflict();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/imem_port_arbiter.md
IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 10, meaning memory word-address width (2^AW 32-bit words).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- f_req  in  1  fetch read request.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch access issued this cycle.
- f_rvalid  out  1  fetch read data valid.
- f_rdata  out  32  fetch read data.
- f_err  out  1  fetch address out of range; qualifies f_rvalid.
- l_req  in  1  loader request.
- l_we  in  1  loader write, 1 = write, 0 = read.
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader write data.
- l_lock  in  1  loader requests exclusive session.
- l_gnt  out  1  loader access issued this cycle.
- l_rvalid  out  1  loader response valid.
- l_rdata  out  32  loader read data.
- m_en  out  1  memory access enable.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory word index.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data, valid one cycle after m_en.
- locked  out  1  high in state LOCKED.
- wr_cnt  out  AW+1  writes accepted in current or last session.

Function
REQ-003 At most one of f_gnt and l_gnt SHALL be high in any cycle.
REQ-004 A grant SHALL be combinational in the request cycle. It SHALL drive m_en = 1 and m_addr = addr[AW+1:2]. For a loader grant it SHALL also drive m_we = l_we and m_wdata = l_wdata.
REQ-005 Byte-address bits [1:0] SHALL be ignored.
REQ-006 Out-of-range handling: an address with any of bits [31:AW+2] nonzero SHALL still be granted, with m_en = 0.
- The response SHALL carry rdata = 0.
- For a fetch, f_err = 1 with f_rvalid.
REQ-007 f_rvalid or l_rvalid SHALL pulse exactly one cycle after the grant. rdata SHALL equal m_rdata, or 0 for writes and out-of-range accesses.
REQ-008 The FSM SHALL have states IDLE and LOCKED.
REQ-009 In IDLE, with a single request, that requester SHALL be granted. With both requesting, the winner follows REQ-016.
REQ-010 IDLE to LOCKED SHALL occur on the edge after a loader grant with l_lock = 1.
- wr_cnt SHALL clear on that edge.
- The granting access SHALL count toward wr_cnt if it is a write.
REQ-011 In LOCKED:
- f_gnt SHALL be 0.
- Every l_req SHALL be granted.
- LOCKED to IDLE SHALL occur on the first edge with l_lock = 0, with or without a final grant.
REQ-012 wr_cnt SHALL increment on each granted loader write, including out-of-range writes, and saturate at 2^AW.
REQ-013 Simultaneous write and fetch to the same word SHALL be impossible by REQ-003. A fetch in the following cycle SHALL read the new data.

Reset
REQ-014 While rst = 0, the block SHALL hold:
- State = IDLE.
- All outputs = 0, including rvalid, rdata, f_err, locked and wr_cnt.
- Pending responses discarded.
- Last-winner register = fetch.
REQ-015 Reset assertion mid-access SHALL suppress the response in the following cycle.

Configuration
REQ-016 Macro IMEM_RR_EN SHALL select the IDLE arbitration policy.
- Undefined: fixed priority, loader wins on conflict.
- Defined: round-robin. On conflict, the requester not granted last wins. The last-winner register updates on every IDLE grant.

Verification
REQ-017 Reset, then f_req = 1, f_addr = 0x8, memory word 2 = 0xDEADBEEF -> f_gnt = 1 and m_addr = 2 in that cycle; next cycle f_rvalid = 1, f_rdata = 0xDEADBEEF, f_err = 0.
REQ-018 l_lock = 1, l_we = 1, three writes to 0x0/0x4/0x8, f_req held high -> f_gnt = 0 throughout, locked = 1, wr_cnt = 3; after l_lock = 0, locked = 0 and next fetch granted.
REQ-019 f_addr = 0x1000 (AW = 10) -> f_gnt = 1, m_en = 0; next cycle f_rvalid = 1, f_err = 1, f_rdata = 0.
REQ-020 Both requesting for 4 cycles, loader read-only, l_lock = 0 -> without IMEM_RR_EN, loader granted 4/4; with it, grants alternate L,F,L,F.
REQ-021 rst to 0 in cycle after a fetch grant -> f_rvalid stays 0, locked = 0, wr_cnt = 0.
